// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot ROM loader.
package rom_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_WIDTH     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } loader_state_t;

endpackage

// File: rtl/rom_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// Outputs are combinational so the owner can act on the same edge that
// accepts the final byte of a word.
module word_assembler
    import rom_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [7:0]            byte_data,
    output logic                  word_done,
    output logic [WORD_WIDTH-1:0] word
);

    logic [1:0]            byte_idx;
    logic [WORD_WIDTH-1:0] word_q;

    // Current partial word with the incoming byte dropped into its lane.
    always_comb begin
        word = word_q;
        if (byte_en) begin
            word[{byte_idx, 3'b000} +: 8] = byte_data;
        end
        word_done = byte_en && (byte_idx == 2'd3);
    end

    // Byte lane index and partial word storage; index wraps 3 -> 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= 2'd0;
            word_q   <= '0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            word_q   <= '0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + 2'd1;
            word_q   <= word;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot-time ROM loader: bytes -> words -> ROM write port, then checksum.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start after reset
// ST_LOAD  | accepting program bytes, one ROM write per completed word
// ST_CHECK | accepting the 4 checksum bytes
// ST_DONE  | checksum matched, go held high
// ST_FAIL  | checksum mismatch, err held high
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_waddr,
    output logic [WORD_WIDTH-1:0] rom_wdata,
    output logic                  busy,
    output logic                  go,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   loaded_words
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    loader_state_t         state_q;
    loader_state_t         state_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      word_idx_q;
    logic [WORD_WIDTH-1:0] sum_q;
    logic [CNT_W-1:0]      count_clamped;
    logic                  start_ok;
    logic                  xfer;
    logic                  last_word;
    logic                  word_done;
    logic [WORD_WIDTH-1:0] asm_word;

    assign busy         = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign byte_ready   = busy;
    assign go           = (state_q == ST_DONE);
    assign err          = (state_q == ST_FAIL);
    assign loaded_words = word_idx_q;

    assign start_ok      = start && !busy;
    assign xfer          = byte_valid && byte_ready;
    assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign last_word     = ((word_idx_q + CNT_W'(1)) == count_q);

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .byte_en   (xfer),
        .byte_data (byte_data),
        .word_done (word_done),
        .word      (asm_word)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured outside a load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d = (count_clamped == '0) ? ST_CHECK : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_done && last_word) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (word_done) begin
                    state_d = (asm_word == sum_q) ? ST_DONE : ST_FAIL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Word counter, running checksum and registered ROM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            word_idx_q <= '0;
            sum_q      <= '0;
            rom_we     <= 1'b0;
            rom_waddr  <= '0;
            rom_wdata  <= '0;
        end else begin
            rom_we <= 1'b0;
            if (start_ok) begin
                count_q    <= count_clamped;
                word_idx_q <= '0;
                sum_q      <= '0;
            end else if ((state_q == ST_LOAD) && word_done) begin
                rom_we     <= 1'b1;
                rom_waddr  <= word_idx_q[ADDR_WIDTH-1:0];
                rom_wdata  <= asm_word;
                sum_q      <= sum_q + asm_word;
                word_idx_q <= word_idx_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized self-checking bench for rom_loader with a word-level model.
module tb_rom_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [31:0]   rom_wdata;
    logic          busy;
    logic          go;
    logic          err;
    logic [AW:0]   loaded_words;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .word_count   (word_count),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .rom_we       (rom_we),
        .rom_waddr    (rom_waddr),
        .rom_wdata    (rom_wdata),
        .busy         (busy),
        .go           (go),
        .err          (err),
        .loaded_words (loaded_words)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every ROM write seen on the port.
    always @(negedge clk) begin
        if (rom_we) begin
            wa_q.push_back(rom_waddr);
            wd_q.push_back(rom_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gapmode, output int acc_cyc);
        int gap;
        int n;
        gap = 0;
        if (gapmode == 1) gap = $urandom_range(0, 3);
        if (gapmode == 2) gap = ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 2);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        @(negedge clk);
        while (!byte_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!byte_ready) begin
            check("byte_ready_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic do_start(input int count);
        start      = 1'b1;
        word_count = (AW+1)'(count);
        @(posedge clk);
        #1;
        start      = 1'b0;
        word_count = (AW+1)'($urandom);
    endtask

    task automatic run_load(input string name, input int count, input logic [31:0] words[$],
                            input logic [31:0] cksum, input int gapmode, input bit stray);
        int          n;
        int          first_cyc;
        int          last_cyc;
        int          c;
        logic [31:0] sum;
        bit          exp_go;

        n   = (count > (1 << AW)) ? (1 << AW) : count;
        sum = 32'd0;
        for (int i = 0; i < n; i++) sum += words[i];
        exp_go = (sum == cksum);

        wa_q.delete();
        wd_q.delete();
        do_start(count);
        @(negedge clk);
        check({name, " busy_after_start"}, busy, 1);
        check({name, " ready_after_start"}, byte_ready, 1);
        check({name, " go_cleared"}, go, 0);
        check({name, " err_cleared"}, err, 0);
        @(posedge clk);
        #1;

        first_cyc = -1;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(words[i][8*k +: 8], gapmode, c);
                if (first_cyc < 0) first_cyc = c;
            end
            if (stray && i == 0) begin
                do_start($urandom_range(0, 5));
            end
        end
        for (int k = 0; k < 4; k++) begin
            send_byte(cksum[8*k +: 8], gapmode, c);
            if (first_cyc < 0) first_cyc = c;
        end
        last_cyc = c;

        @(negedge clk);
        check({name, " go"}, go, exp_go);
        check({name, " err"}, err, !exp_go);
        check({name, " busy_end"}, busy, 0);
        check({name, " ready_end"}, byte_ready, 0);
        check({name, " loaded_words"}, loaded_words, n);
        if (gapmode == 0 && !stray) begin
            check({name, " latency"}, last_cyc + 1 - first_cyc, 4 * (n + 1));
        end
        check({name, " write_count"}, wa_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wa_q.size()) begin
                check($sformatf("%s waddr%0d", name, i), wa_q[i], i);
                check($sformatf("%s wdata%0d", name, i), wd_q[i], words[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, " go_held"}, go, exp_go);
        check({name, " err_held"}, err, !exp_go);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] s;
        int          cnt;

        reset      = 1'b1;
        start      = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst byte_ready", byte_ready, 0);
        check("rst rom_we", rom_we, 0);
        check("rst rom_waddr", rom_waddr, 0);
        check("rst rom_wdata", rom_wdata, 0);
        check("rst busy", busy, 0);
        check("rst go", go, 0);
        check("rst err", err, 0);
        check("rst loaded_words", loaded_words, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        w = '{32'h0000_0013, 32'h0010_0093};
        run_load("plan_ok", 2, w, 32'h0010_00A6, 0, 1'b0);
        run_load("plan_bad", 2, w, 32'h0010_00A7, 0, 1'b0);
        run_load("plan_gaps", 2, w, 32'h0010_00A6, 2, 1'b0);

        w.delete();
        run_load("zero_cnt", 0, w, 32'h0, 0, 1'b0);

        w.delete();
        s = 32'd0;
        for (int i = 0; i < 256; i++) begin
            w.push_back($urandom);
            s += w[i];
        end
        run_load("cnt300", 300, w, s, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            w.delete();
            s   = 32'd0;
            cnt = $urandom_range(1, 6);
            for (int i = 0; i < cnt; i++) begin
                w.push_back($urandom);
                s += w[i];
            end
            if ($urandom_range(0, 2) == 0) s ^= (32'h1 << $urandom_range(0, 31));
            run_load($sformatf("rand%0d", t), cnt, w, s, $urandom_range(0, 2), (t % 3) == 1);
        end

        // Reset in the middle of the second word of a load.
        w.delete();
        s = 32'd0;
        for (int i = 0; i < 3; i++) begin
            w.push_back($urandom);
            s += w[i];
        end
        do_start(3);
        begin
            int c;
            for (int k = 0; k < 5; k++) send_byte(w[k / 4][8*(k%4) +: 8], 0, c);
        end
        reset = 1'b1;
        #1;
        check("midrst byte_ready", byte_ready, 0);
        check("midrst rom_we", rom_we, 0);
        check("midrst rom_waddr", rom_waddr, 0);
        check("midrst rom_wdata", rom_wdata, 0);
        check("midrst busy", busy, 0);
        check("midrst go", go, 0);
        check("midrst err", err, 0);
        check("midrst loaded_words", loaded_words, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_load("reload", 3, w, s, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
